// File: rtl/board_level_data_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : board_level_data_pkg
//  Description : Symbol type codes, IDLE symbol and the item-to-symbol
//                encoder shared by the lane transmitter and receiver decoder.
//                A symbol is {type[1:0], payload}. Only DATA carries a payload.
//                The payload is carried at MAX_DW bits so the encoder can
//                serve any DATA_WIDTH below that. Callers keep the low
//                DATA_WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_level_data_pkg;

  localparam int unsigned MAX_DW = 32;

  typedef enum logic [1:0] {
    SYM_IDLE  = 2'b00,
    SYM_DATA  = 2'b01,
    SYM_START = 2'b10,
    SYM_END   = 2'b11
  } sym_type_e;

  typedef struct packed {
    sym_type_e               kind;
    logic [MAX_DW-1:0]       payload;
  } sym_t;

  localparam sym_t IDLE_SYM = '{kind: SYM_IDLE, payload: '0};

  // START takes priority when an item is flagged as both start and end.
  function automatic sym_t encode_sym(input logic fs, input logic fe,
                                      input logic [MAX_DW-1:0] d);
    sym_t r;
    r = IDLE_SYM;
    if (fs) begin
      r.kind = SYM_START;
    end else if (fe) begin
      r.kind = SYM_END;
    end else begin
      r.kind    = SYM_DATA;
      r.payload = d;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_level_data_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : board_level_data_sync_fifo
//  Description : Single-clock FIFO. Head word is read from the flop array at
//                the read pointer, so a word written in cycle t is visible at
//                the head from t+1. Pushes while full and pops while empty are
//                ignored. The count is one bit wider than the pointers, so
//                full and empty are never ambiguous.
//  Ports       : clk, rst (sync, active-high)
//                push_i, wdata_i[WIDTH]   write side
//                pop_i, rdata_o[WIDTH]    read side (rdata_o = head)
//                full_o, empty_o, count_o occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module board_level_data_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             w_push, w_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i  && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only words below count are ever observed.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/board_level_data_transmitter_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : board_level_data_transmitter_lanes
//  Description : Buffers tagged frame items, encodes each into a SYM_W-bit
//                symbol and serialises it MSB first over LANES wires, one
//                beat per bit_tick. IDLE is sent whenever the buffer is
//                empty at a symbol boundary.
//  Ports       : clk, rst (sync, active-high)
//                bit_tick                 advance serialiser one beat
//                frame_start, frame_end   item markers (data ignored)
//                data[DATA_WIDTH], we     item write
//                full, overflow (sticky)  buffer status
//                serial_data[LANES]       current beat, lane LANES-1 = MSBs
//                sym_align                first beat of a symbol
//                level, almost_full       only with BOARD_LEVEL_TX_LEVEL_EN
//  Config      : `define BOARD_LEVEL_TX_LEVEL_EN adds the level/almost_full
//                occupancy ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_level_data_transmitter_lanes
  import board_level_data_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_tick,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  output logic                  full,
  output logic                  overflow,
  output logic [LANES-1:0]      serial_data,
  output logic                  sym_align
`ifdef BOARD_LEVEL_TX_LEVEL_EN
  ,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                  almost_full
`endif
);

  localparam int SYM_W = DATA_WIDTH + 2;
  localparam int BEATS = SYM_W / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  if ((SYM_W % LANES) != 0) begin : g_check_lanes
    $error("LANES must divide DATA_WIDTH+2");
  end

  logic [SYM_W-1:0]      shift_q, shift_d;
  logic [BW-1:0]         beat_q,  beat_d;
  logic                  overflow_q, overflow_d;

  logic                  w_empty;
  logic [SYM_W-1:0]      w_head;
  logic [CW-1:0]         w_count;
  logic                  w_boundary;
  logic                  w_pop;
  sym_t                  w_enc;
  logic [SYM_W-1:0]      w_sym;
  logic [MAX_DW-DATA_WIDTH-1:0] w_pad_unused;

  // Stored item layout is {frame_start, frame_end, data}.
  board_level_data_sync_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (we),
    .wdata_i ({frame_start, frame_end, data}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // The last beat's tick is the symbol boundary: it pops and reloads.
  assign w_boundary = bit_tick && (beat_q == BW'(BEATS - 1));
  assign w_pop      = w_boundary && !w_empty;

  assign w_enc        = encode_sym(w_head[SYM_W-1], w_head[SYM_W-2],
                                   MAX_DW'(w_head[DATA_WIDTH-1:0]));
  assign w_sym        = {w_enc.kind, w_enc.payload[DATA_WIDTH-1:0]};
  assign w_pad_unused = w_enc.payload[MAX_DW-1:DATA_WIDTH];

  always_comb begin
    shift_d    = shift_q;
    beat_d     = beat_q;
    overflow_d = overflow_q | (we & full);
    if (bit_tick) begin
      if (w_boundary) begin
        beat_d  = '0;
        shift_d = w_pop ? w_sym : SYM_W'(IDLE_SYM);
      end else begin
        beat_d  = beat_q + BW'(1);
        shift_d = shift_q << LANES;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  assign serial_data = shift_q[SYM_W-1 -: LANES];
  assign sym_align   = (beat_q == '0);
  assign overflow    = overflow_q;

`ifdef BOARD_LEVEL_TX_LEVEL_EN
  assign level       = ($clog2(FIFO_DEPTH+1))'(w_count);
  assign almost_full = (w_count >= CW'(AF_THRESH));
`else
  logic w_count_unused;
  assign w_count_unused = ^w_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_level_data_transmitter_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_level_data_transmitter_lanes
//  Description : Self-checking bench. Two instances (LANES=1 and LANES=2)
//                share one stimulus stream. A queue-level model predicts
//                every output each cycle. Symbols are also reassembled from
//                the wires and compared with hand-written expected lists.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_level_data_transmitter_lanes;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_tick = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic [5:0] data = '0;
  logic       we = 1'b0;

  logic       full1, ovf1, al1, full2, ovf2, al2;
  logic [0:0] sd1;
  logic [1:0] sd2;
`ifdef BOARD_LEVEL_TX_LEVEL_EN
  logic [4:0] lvl1, lvl2;
  logic       af1, af2;
`endif

  always #5 clk = ~clk;

  board_level_data_transmitter_lanes #(.DATA_WIDTH(6), .LANES(1), .FIFO_DEPTH(16), .AF_THRESH(12)) u_dut1 (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .frame_start(frame_start), .frame_end(frame_end),
    .data(data), .we(we), .full(full1), .overflow(ovf1), .serial_data(sd1), .sym_align(al1)
`ifdef BOARD_LEVEL_TX_LEVEL_EN
    , .level(lvl1), .almost_full(af1)
`endif
  );

  board_level_data_transmitter_lanes #(.DATA_WIDTH(6), .LANES(2), .FIFO_DEPTH(16), .AF_THRESH(12)) u_dut2 (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .frame_start(frame_start), .frame_end(frame_end),
    .data(data), .we(we), .full(full2), .overflow(ovf2), .serial_data(sd2), .sym_align(al2)
`ifdef BOARD_LEVEL_TX_LEVEL_EN
    , .level(lvl2), .almost_full(af2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (per instance k: 0 -> LANES=1, 1 -> LANES=2)
  int unsigned qbuf [2][64];
  int          qh [2], qt [2];
  int          m_sym [2], m_beat [2], m_ovf [2];

  function automatic int lanes_of(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int beats_of(input int k); return 8 / lanes_of(k); endfunction

  function automatic int enc(input logic s, input logic e, input logic [5:0] d);
    if (s) return 8'h80;
    if (e) return 8'hC0;
    return 8'h40 | int'(d);
  endfunction

  task automatic model_update(input logic r, input logic t, input logic s, input logic e,
                              input logic [5:0] d, input logic w);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        qh[k] = 0; qt[k] = 0; m_sym[k] = 0; m_beat[k] = 0; m_ovf[k] = 0;
      end else begin
        int  size;
        bit  fullpre;
        size    = qt[k] - qh[k];
        fullpre = (size == 16);
        if (t) begin
          if (m_beat[k] == beats_of(k) - 1) begin
            m_beat[k] = 0;
            if (size > 0) begin
              m_sym[k] = int'(qbuf[k][qh[k] % 64]);
              qh[k]++;
            end else begin
              m_sym[k] = 0;
            end
          end else begin
            m_beat[k]++;
          end
        end
        if (w) begin
          if (fullpre) m_ovf[k] = 1;
          else begin
            qbuf[k][qt[k] % 64] = int'(enc(s, e, d));
            qt[k]++;
          end
        end
      end
    end
  endtask

  function automatic int exp_sd(input int k);
    int l;
    l = lanes_of(k);
    return (m_sym[k] >> (8 - l * (m_beat[k] + 1))) & ((1 << l) - 1);
  endfunction

  task automatic compare_all();
    chk("full1", int'(full1), (qt[0] - qh[0]) == 16 ? 1 : 0);
    chk("ovf1",  int'(ovf1),  m_ovf[0]);
    chk("sd1",   int'(sd1),   exp_sd(0));
    chk("align1", int'(al1),  m_beat[0] == 0 ? 1 : 0);
    chk("full2", int'(full2), (qt[1] - qh[1]) == 16 ? 1 : 0);
    chk("ovf2",  int'(ovf2),  m_ovf[1]);
    chk("sd2",   int'(sd2),   exp_sd(1));
    chk("align2", int'(al2),  m_beat[1] == 0 ? 1 : 0);
`ifdef BOARD_LEVEL_TX_LEVEL_EN
    chk("level1", int'(lvl1), qt[0] - qh[0]);
    chk("af1",    int'(af1),  (qt[0] - qh[0]) >= 12 ? 1 : 0);
    chk("level2", int'(lvl2), qt[1] - qh[1]);
    chk("af2",    int'(af2),  (qt[1] - qh[1]) >= 12 ? 1 : 0);
`endif
  endtask

  // ---------------- symbol reassembly from the wires
  int cap [2][512];
  int ncap [2];
  int acc [2], acnt [2];

  task automatic collect(input logic r, input logic t);
    if (r) begin
      for (int k = 0; k < 2; k++) begin ncap[k] = 0; acc[k] = 0; acnt[k] = 0; end
    end
    if (r || t) begin
      for (int k = 0; k < 2; k++) begin
        int sdv, alv;
        sdv = (k == 0) ? int'(sd1) : int'(sd2);
        alv = (k == 0) ? int'(al1) : int'(al2);
        if (alv != 0) begin acc[k] = sdv; acnt[k] = 1; end
        else begin acc[k] = (acc[k] << lanes_of(k)) | sdv; acnt[k]++; end
        if (acnt[k] == beats_of(k) && ncap[k] < 512) begin
          cap[k][ncap[k]] = acc[k] & 8'hFF;
          ncap[k]++;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic s, input logic e,
                     input logic [5:0] d, input logic w);
    rst = r; bit_tick = t; frame_start = s; frame_end = e; data = d; we = w;
    @(posedge clk);
    model_update(r, t, s, e, d, w);
    #1;
    collect(r, t);
    compare_all();
  endtask

  task automatic check_caps(input int k, input int n, input int exp_list[16], input string tag);
    int nn;
    nn = 0;
    for (int i = 0; i < ncap[k]; i++) begin
      if (cap[k][i] != 0) begin
        if (nn < n && nn < 16) chk($sformatf("%s_sym%0d_lane%0d", tag, nn, k), cap[k][i], exp_list[nn]);
        nn++;
      end
    end
    chk($sformatf("%s_count_lane%0d", tag, k), nn, n);
  endtask

  // ---------------- table vectors (expectations for the LANES=1 instance)
  typedef struct packed {
    logic r, t, s, e;
    logic [5:0] d;
    logic w;
    logic f, o, sd, al;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic t, input logic [5:0] d, input logic w,
                               input logic f, input logic o, input logic sd, input logic al);
    vec_t v;
    v.r = r; v.t = t; v.s = 1'b0; v.e = 1'b0; v.d = d; v.w = w;
    v.f = f; v.o = o; v.sd = sd; v.al = al;
    return v;
  endfunction

  vec_t tbl [18];
  int   exp_list [16];
  logic [7:0] bits6a;

  initial begin
    // Reset, write 0x2A idle, 7 ticks through the reset IDLE symbol,
    // then 0x6A = 0110_1010 MSB first, then IDLE.
    bits6a = 8'h6A;
    tbl[0] = mkv(1, 0, 6'h00, 0, 0, 0, 0, 1);
    tbl[1] = mkv(0, 0, 6'h2A, 1, 0, 0, 0, 1);
    for (int i = 2; i <= 8; i++) tbl[i] = mkv(0, 1, 6'h00, 0, 0, 0, 0, 0);
    tbl[9] = mkv(0, 1, 6'h00, 0, 0, 0, bits6a[7], 1);
    for (int i = 10; i <= 16; i++) tbl[i] = mkv(0, 1, 6'h00, 0, 0, 0, bits6a[16 - i], 0);
    tbl[17] = mkv(0, 1, 6'h00, 0, 0, 0, 0, 1);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].e, tbl[i].d, tbl[i].w);
      chk($sformatf("tbl%0d_full", i),  int'(full1), int'(tbl[i].f));
      chk($sformatf("tbl%0d_ovf", i),   int'(ovf1),  int'(tbl[i].o));
      chk($sformatf("tbl%0d_sd", i),    int'(sd1),   int'(tbl[i].sd));
      chk($sformatf("tbl%0d_align", i), int'(al1),   int'(tbl[i].al));
    end

    // Idle line: only IDLE symbols, full stays low.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("idle_syms_lane0", ncap[0], 4);
    chk("idle_syms_lane1", ncap[1], 8);
    for (int i = 0; i < 16; i++) exp_list[i] = 0;
    check_caps(0, 0, exp_list, "idle");
    check_caps(1, 0, exp_list, "idle");

    // Frame sequence, including START+END (START wins), written while ticking.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 6'h00, 1);
    cyc(0, 1, 0, 0, 6'h15, 1);
    cyc(0, 1, 0, 1, 6'h00, 1);
    cyc(0, 1, 0, 0, 6'h2A, 1);
    cyc(0, 1, 1, 1, 6'h3F, 1);
    for (int i = 0; i < 100; i++) cyc(0, 1, 0, 0, 0, 0);
    exp_list[0] = 8'h80; exp_list[1] = 8'h55; exp_list[2] = 8'hC0;
    exp_list[3] = 8'h6A; exp_list[4] = 8'h80;
    check_caps(0, 5, exp_list, "frame");
    check_caps(1, 5, exp_list, "frame");

    // Fill to full with no ticks; 17th write is dropped and sets overflow.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, 0, 6'(i + 1), 1);
      if (i == 14) chk("full_before16", int'(full1), 0);
      if (i == 15) begin
        chk("full_after16", int'(full1), 1);
        chk("ovf_after16", int'(ovf1), 0);
      end
    end
    chk("ovf_after17", int'(ovf1), 1);
    chk("ovf2_after17", int'(ovf2), 1);
    for (int i = 0; i < 160; i++) cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) exp_list[i] = 8'h40 | (i + 1);
    check_caps(0, 16, exp_list, "fill");
    check_caps(1, 16, exp_list, "fill");
    chk("ovf_sticky", int'(ovf1), 1);

    // Reset mid-symbol with items buffered.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 6'(i + 7), 1);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 6'h3F, 1);
    chk("rst_sd1", int'(sd1), 0);
    chk("rst_align1", int'(al1), 1);
    chk("rst_full1", int'(full1), 0);
    chk("rst_ovf1", int'(ovf1), 0);
    chk("rst_sd2", int'(sd2), 0);
    chk("rst_align2", int'(al2), 1);
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) exp_list[i] = 0;
    check_caps(0, 0, exp_list, "after_rst");
    check_caps(1, 0, exp_list, "after_rst");

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 6) == 0,
          ($urandom % 6) == 0, 6'($urandom), ($urandom % 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
